// File: rtl/lzc_norm_pkg.sv
// Shared types and width helpers for the mantissa normalizer.
package lzc_norm_pkg;

  function automatic int count_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int NORM_WIDTH = 16;
  localparam int NORM_EXP_W = 8;
  localparam int NORM_COUNT = count_w(NORM_WIDTH);

  // Output register layout; change NORM_WIDTH/NORM_EXP_W to build other widths.
  typedef struct packed {
    logic [NORM_WIDTH-1:0] mant;
    logic [NORM_EXP_W-1:0] exp;
    logic [NORM_COUNT-1:0] shift;
    logic                  zero;
    logic                  denorm;
  } norm_result_t;

endpackage

// File: rtl/lzc_normalizer_lzc.sv
// Leading-zero counter: log2(WIDTH) halving steps, each testing the top 2^k bits.
module LZC_proposed #(
  parameter int  WIDTH = 16,
  localparam int COUNT = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [COUNT-1:0] n_Z,
  output logic             n_V
);

  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] hi_mask;

  always_comb begin
    v       = x_i;
    hi_mask = '0;
    n_Z     = '0;
    for (int k = COUNT - 1; k >= 0; k--) begin
      hi_mask = {WIDTH{1'b1}} << (WIDTH - (1 << k));
      if ((v & hi_mask) == '0) begin
        n_Z[k] = 1'b1;
        v      = v << (1 << k);
      end
    end
  end

  // n_Z is meaningless when the input is all zeros; n_V flags that case.
  assign n_V = |x_i;

endmodule

// File: rtl/lzc_normalizer.sv
// Two-stage mantissa normalizer: S1 input register, S2 count+shift into the output register.
module lzc_normalizer
  import lzc_norm_pkg::*;
#(
  parameter int  WIDTH = NORM_WIDTH,
  parameter int  EXP_W = NORM_EXP_W,
  localparam int COUNT = count_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [COUNT-1:0] out_shift,
  output logic             out_zero,
  output logic             out_denorm
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and a held item keeps its data stable until taken.
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_mant_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic             out_valid_q;
  norm_result_t     out_q;
  norm_result_t     res_d;

  logic             en_out;
  logic             en_s1;
  logic [COUNT-1:0] lz;
  logic             lz_v;
  logic [COUNT-1:0] shift;

  assign en_out   = ~out_valid_q | out_ready;
  assign en_s1    = ~s1_valid_q | en_out;
  assign in_ready = en_s1;

  LZC_proposed #(.WIDTH(WIDTH)) u_lzc (
    .x_i (s1_mant_q),
    .n_Z (lz),
    .n_V (lz_v)
  );

  always_comb begin
    res_d = '0;
    shift = '0;
    if (!lz_v) begin
      res_d.zero = 1'b1;
    end else if (EXP_W'(lz) <= s1_exp_q) begin
      shift     = lz;
      res_d.exp = s1_exp_q - EXP_W'(lz);
    end else begin
      // exp < lz < WIDTH here, so the low COUNT bits hold the whole exponent.
      shift        = s1_exp_q[COUNT-1:0];
      res_d.denorm = 1'b1;
    end
    res_d.shift = shift;
    res_d.mant  = s1_mant_q << shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (en_s1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mant_q <= in_mant;
          s1_exp_q  <= in_exp;
        end
      end
      if (en_out) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_q <= res_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_mant   = out_q.mant;
  assign out_exp    = out_q.exp;
  assign out_shift  = out_q.shift;
  assign out_zero   = out_q.zero;
  assign out_denorm = out_q.denorm;

endmodule

// File: doc/lzc_normalizer.md
# lzc_normalizer

Pipelined mantissa normalizer that sits directly downstream of the leading-zero counter. It accepts an unnormalized mantissa/exponent pair over a valid/ready handshake and left-shifts the mantissa so its MSB is 1. The exponent is reduced by the shift amount, saturating into a denormal result on exponent underflow. Throughput is one result per clock with two-cycle latency, feeding the rounding/packing stage of the FP datapath.

## Interface
- WIDTH, 16, mantissa width; must be a power of two, ≥ 2 (the counter only supports power-of-two widths)
- EXP_W, 8, exponent width; unsigned, biased
- COUNT, $clog2(WIDTH), shift-count width; derived, not overridden
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input pair present
- in_ready  output  1  stage can accept; combinational from pipeline state and out_ready
- in_mant  input  WIDTH  unnormalized mantissa
- in_exp  input  EXP_W  exponent of in_mant
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts
- out_mant  output  WIDTH  normalized mantissa
- out_exp  output  EXP_W  adjusted exponent
- out_shift  output  COUNT  shift actually applied
- out_zero  output  1  in_mant was all zeros
- out_denorm  output  1  full normalization blocked by exponent underflow

## Operation
- Stage 1 (S1): on an accepted transfer (in_valid & in_ready), register in_mant, in_exp and the valid bit.
- Stage 2 (S2): from the S1 registers, compute lz = leading-zero count with the counter sub-module; counter valid = mantissa nonzero.
  - zero case (counter valid = 0): out_mant = 0, out_exp = 0, out_shift = 0, out_zero = 1, out_denorm = 0.
  - lz ≤ exp: shift = lz, out_exp = exp − lz, out_denorm = 0. lz == exp yields exp 0 with a normalized mantissa, and denorm stays 0.
  - lz > exp: shift = exp (truncated to COUNT bits; only the low bits matter because exp < lz < WIDTH), out_exp = 0, out_denorm = 1.
  - out_mant = mant << shift, zero-filled from the LSB; no bits are lost, since shift ≤ lz.
- Register the S2 result into the output register with out_valid.
- Stall logic:
  - en_out = ~out_valid | out_ready
  - en_s1 = ~s1_valid | en_out
  - in_ready = en_s1
  - No bubbles inserted: a full pipeline streams at 1/cycle while out_ready = 1.
- When a stage is not enabled, its registers hold. Output data stays stable while out_valid & ~out_ready.
- A valid bit clears when its stage is enabled and no new item enters. Data registers may keep stale values.

## Timing
- Reset (rst = 1 at edge): s1_valid = 0 and out_valid = 0. out_mant, out_exp, out_shift, out_zero and out_denorm all = 0.
- in_ready reads 1 in the first cycle after reset.
- Reset mid-operation: all in-flight items are discarded with no partial output. Inputs presented during the rst cycle are not accepted.
- Latency: an item accepted at edge k is on the outputs with out_valid = 1 in the cycle after edge k+1, i.e. 2 cycles.
- Backpressure: with out_ready = 0 and both stages full, in_ready = 0 in the same cycle. Capacity is 2 items.
- Simultaneous events: out_ready = 1 and in_valid = 1 with a full pipeline causes output pop, S1→out move and input accept all at one edge.
- The counter and shifter form one combinational S2 path. The critical path is the count of log2(WIDTH) levels plus a barrel shift of COUNT levels.

## Structure
- Package lzc_norm_pkg holds:
  - the COUNT derivation function
  - a packed struct norm_result_t {mant, exp, shift, zero, denorm}, used for the output register
- Sub-module: the existing LZC_proposed leading-zero counter, instantiated once in S2 (WIDTH → n_Z, n_V).
- The barrel shifter stays inline.

## Test plan
Cases 1–4 and 6 use WIDTH = 16, EXP_W = 8.
- Normal case: mant 0x0001, exp 20 → out_mant 0x8000, out_exp 5, out_shift 15, zero 0, denorm 0, valid 2 cycles after accept.
- Underflow: mant 0x0010, exp 3 → out_mant 0x0080, out_exp 0, out_shift 3, denorm 1. Also mant 0x0010, exp 11 → out_mant 0x8000, out_exp 0, denorm 0.
- Zero and already-normalized inputs: mant 0x0000, exp 7 → zero 1, mant 0, exp 0. Also mant 0x8000, exp 0 → out_mant 0x8000, exp 0, shift 0, denorm 0.
- Backpressure: stream 5 items back-to-back while holding out_ready = 0 for cycles 2–5.
  - in_ready drops once 2 items are held.
  - Output stays stable during the stall.
  - All 5 items emerge in order, with no loss or duplication.
  - Then 1/cycle throughput with out_ready = 1.
- Reset mid-stream: assert rst with 2 items in flight → next cycle out_valid 0 and in_ready 1; no stale item ever appears.
- Random: 10k random mant/exp pairs with random valid/ready, checked against a reference model. Repeat with WIDTH = 2 and WIDTH = 32.
